// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the ALU issue path.
//   - RV32I opcode and funct3/funct7 field values used by the decoder.
//   - ALU operation codes, shared with the ALU itself.
//   - issue_entry_t: one decoded entry {in1, in2, op, illegal} as held in the skid buffer.
package alu_issue_pkg;

    localparam int unsigned Xlen = 32;

    // Major opcodes
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    // ALU operation codes
    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluXor  = 4'b0101;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSrl  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;
    localparam logic [3:0] AluSll  = 4'b1010;
    localparam logic [3:0] AluSlt  = 4'b1100;
    localparam logic [3:0] AluSltu = 4'b1101;
    localparam logic [3:0] AluNop  = 4'b1111;

    typedef struct packed {
        logic [Xlen-1:0] in1;
        logic [Xlen-1:0] in2;
        logic [3:0]      op;
        logic            illegal;
    } issue_entry_t;

    localparam issue_entry_t EntryReset = '{in1: '0, in2: '0, op: AluNop, illegal: 1'b0};

    // OP/OP-IMM funct3 -> ALU op; alt selects SUB/SRA in the two slots that have a variant.
    function automatic logic [3:0] funct3_to_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            F3AddSub: op = alt ? AluSub : AluAdd;
            F3Sll:    op = AluSll;
            F3Slt:    op = AluSlt;
            F3Sltu:   op = AluSltu;
            F3Xor:    op = AluXor;
            F3Srl:    op = alt ? AluSra : AluSrl;
            F3Or:     op = AluOr;
            F3And:    op = AluAnd;
            default:  op = AluNop;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode into ALU operands.
//   instr, pc, rs1_data, rs2_data : instruction word, its address, register reads
//   in1, in2, op                  : ALU operands and operation code
//   illegal                       : unrecognised encoding; in1/in2 forced to 0, op to NOP
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [Xlen-1:0] instr,
    input  logic [Xlen-1:0] pc,
    input  logic [Xlen-1:0] rs1_data,
    input  logic [Xlen-1:0] rs2_data,
    output logic [Xlen-1:0] in1,
    output logic [Xlen-1:0] in2,
    output logic [3:0]      op,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [Xlen-1:0] imm_i;
    logic [Xlen-1:0] imm_s;
    logic [Xlen-1:0] imm_u;
    logic [Xlen-1:0] in1_raw;
    logic [Xlen-1:0] in2_raw;
    logic [3:0]      op_raw;
    logic            bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        in1_raw = '0;
        in2_raw = '0;
        op_raw  = AluNop;
        bad     = 1'b0;
        case (opcode)
            OpcOp: begin
                in1_raw = rs1_data;
                in2_raw = rs2_data;
                op_raw  = funct3_to_op(funct3, instr[30]);
                // Alternate funct7 only exists for SUB and SRA.
                bad = !((funct7 == Funct7Base) ||
                        ((funct7 == Funct7Alt) && ((funct3 == F3AddSub) || (funct3 == F3Srl))));
            end
            OpcOpImm: begin
                in1_raw = rs1_data;
                in2_raw = imm_i;
                // ADDI has no SUB form: instr[30] is just an immediate bit there.
                op_raw  = funct3_to_op(funct3, instr[30] & (funct3 == F3Srl));
                if (funct3 == F3Sll) begin
                    bad = (funct7 != Funct7Base);
                end else if (funct3 == F3Srl) begin
                    bad = !((funct7 == Funct7Base) || (funct7 == Funct7Alt));
                end
            end
            OpcLoad: begin
                in1_raw = rs1_data;
                in2_raw = imm_i;
                op_raw  = AluAdd;
            end
            OpcStore: begin
                in1_raw = rs1_data;
                in2_raw = imm_s;
                op_raw  = AluAdd;
            end
            OpcLui: begin
                in2_raw = imm_u;
                op_raw  = AluAdd;
            end
            OpcAuipc: begin
                in1_raw = pc;
                in2_raw = imm_u;
                op_raw  = AluAdd;
            end
            OpcBranch: begin
                in1_raw = rs1_data;
                in2_raw = rs2_data;
                case (funct3)
                    F3Beq, F3Bne:   op_raw = AluSub;
                    F3Blt, F3Bge:   op_raw = AluSlt;
                    F3Bltu, F3Bgeu: op_raw = AluSltu;
                    default:        bad    = 1'b1;
                endcase
            end
            OpcJal, OpcJalr: begin
                // Link value pc + 4
                in1_raw = pc;
                in2_raw = 32'd4;
                op_raw  = AluAdd;
            end
            default: bad = 1'b1;
        endcase
    end

    assign illegal = bad;
    assign in1     = bad ? '0 : in1_raw;
    assign in2     = bad ? '0 : in2_raw;
    assign op      = bad ? AluNop : op_raw;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I instructions into ALU operands behind a two-entry skid buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous discard of all buffered entries (and any concurrent input)
//   in_valid/in_ready   : upstream handshake for instr/pc/rs1_data/rs2_data
//   out_valid/out_ready : downstream handshake for alu_in1/alu_in2/alu_op/illegal
// Outputs come straight from the head register, so they are stable while stalled and
// in_ready depends only on the registered entry count.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Xlen-1:0] instr,
    input  logic [Xlen-1:0] pc,
    input  logic [Xlen-1:0] rs1_data,
    input  logic [Xlen-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Xlen-1:0] alu_in1,
    output logic [Xlen-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic            illegal
);

    logic [Xlen-1:0] dec_in1;
    logic [Xlen-1:0] dec_in2;
    logic [3:0]      dec_op;
    logic            dec_illegal;
    issue_entry_t    dec;
    issue_entry_t    head_q, head_d;
    issue_entry_t    tail_q, tail_d;
    logic [1:0]      count_q, count_d;
    logic            push;
    logic            pop;

    alu_issue_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .in1      (dec_in1),
        .in2      (dec_in2),
        .op       (dec_op),
        .illegal  (dec_illegal)
    );

    assign dec = '{in1: dec_in1, in2: dec_in2, op: dec_op, illegal: dec_illegal};

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // head holds the oldest entry, tail the second one when two are buffered.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = dec;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = dec;
                    end else if (push) begin
                        tail_d  = dec;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= EntryReset;
            tail_q  <= EntryReset;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign alu_in1 = head_q.in1;
    assign alu_in2 = head_q.in2;
    assign alu_op  = head_q.op;
    assign illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed stimulus with a queue-based reference model checked every cycle,
// plus literal expectations for the key decode and buffering cases.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_op;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];
    exp_t e;
    logic do_pop;
    logic do_push;

    // funct3 -> op tables for OP/OP-IMM (base form) and BRANCH (4'hF marks illegal)
    logic [3:0] alu_tbl [0:7] = '{4'h2, 4'hA, 4'hC, 4'hD, 4'h5, 4'h8, 4'h1, 4'h0};
    logic [3:0] br_tbl  [0:7] = '{4'h6, 4'h6, 4'hF, 4'hF, 4'hC, 4'hC, 4'hD, 4'hD};

    logic [31:0] stream [0:17] = '{
        32'h002081B3, 32'h40208233, 32'h40435293, 32'h40209233, 32'hABCDE0B7, 32'hFE20AE23,
        32'h0020C063, 32'h0020A063, 32'h000000EF, 32'h000080E7, 32'h00812083, 32'hFFF16093,
        32'h003140B3, 32'h403150B3, 32'h003130B3, 32'h40109093, 32'h0000007F, 32'h00002097};

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_op    (alu_op),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference decode, straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [31:0] imm_i;
        logic signed [31:0] imm_s;
        logic [31:0] imm_u;
        opc   = i[6:0];
        f3    = i[14:12];
        f7    = i[31:25];
        imm_i = $signed(i[31:20]);
        imm_s = $signed({i[31:25], i[11:7]});
        imm_u = i & 32'hFFFFF000;
        r.in1 = 32'd0;
        r.in2 = 32'd0;
        r.op  = 4'hF;
        r.ill = 1'b1;
        if (opc == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
            r.in1 = a;
            r.in2 = b;
            r.op  = (f3 == 3'd0 && f7 == 7'h20) ? 4'h6 :
                    (f3 == 3'd5 && f7 == 7'h20) ? 4'h9 : alu_tbl[f3];
            r.ill = 1'b0;
        end else if (opc == 7'h13 && !(f3 == 3'd1 && f7 != 7'h00) &&
                     !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
            r.in1 = a;
            r.in2 = imm_i;
            r.op  = (f3 == 3'd5 && f7 == 7'h20) ? 4'h9 : alu_tbl[f3];
            r.ill = 1'b0;
        end else if (opc == 7'h03 || opc == 7'h23) begin
            r.in1 = a;
            r.in2 = (opc == 7'h03) ? imm_i : imm_s;
            r.op  = 4'h2;
            r.ill = 1'b0;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            r.in1 = (opc == 7'h17) ? p : 32'd0;
            r.in2 = imm_u;
            r.op  = 4'h2;
            r.ill = 1'b0;
        end else if (opc == 7'h63 && br_tbl[f3] != 4'hF) begin
            r.in1 = a;
            r.in2 = b;
            r.op  = br_tbl[f3];
            r.ill = 1'b0;
        end else if (opc == 7'h6F || opc == 7'h67) begin
            r.in1 = p;
            r.in2 = 32'd4;
            r.op  = 4'h2;
            r.ill = 1'b0;
        end
        return r;
    endfunction

    // Compare process: check DUT against the model queue, then apply this cycle's transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst alu_in1", alu_in1, 32'd0);
            chk("rst alu_in2", alu_in2, 32'd0);
            chk("rst alu_op", {28'd0, alu_op}, 32'hF);
            chk("rst illegal", {31'd0, illegal}, 32'd0);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("alu_in1", alu_in1, q[0].in1);
                chk("alu_in2", alu_in2, q[0].in2);
                chk("alu_op", {28'd0, alu_op}, {28'd0, q[0].op});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
            end
            if (flush) begin
                q.delete();
            end else begin
                do_pop  = (q.size() > 0) && out_ready;
                do_push = in_valid && (q.size() < 2);
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e = model(instr, pc, rs1_data, rs2_data);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
    endtask

    // Single entry with out_ready=1; checks the output the cycle after acceptance.
    task automatic one_lit(input string nm, input logic [31:0] i, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [3:0] xop, input logic xill);
        drive(i, p, a, b);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, " valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " in1"}, alu_in1, x1);
        chk({nm, " in2"}, alu_in2, x2);
        chk({nm, " op"}, {28'd0, alu_op}, {28'd0, xop});
        chk({nm, " illegal"}, {31'd0, illegal}, {31'd0, xill});
        tick();
    endtask

    initial begin
        exp_t m;
        int idx;
        logic acc;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset op", {28'd0, alu_op}, 32'hF);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

        // Pin the model with hand-decoded values
        m = model(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("model add", {m.in1[7:0], m.in2[7:0], 12'd0, m.op}, {8'd5, 8'd7, 12'd0, 4'h2});
        m = model(32'h0020A063, 32'h0, 32'd5, 32'd7);
        chk("model beq f3=010", {m.in1[3:0], m.in2[3:0], 19'd0, m.ill, m.op}, 32'h1F);
        m = model(32'h000000EF, 32'h40, 32'd5, 32'd7);
        chk("model jal", m.in1 + (m.in2 << 16), 32'h0004_0040);
        m = model(32'hFE20AE23, 32'h0, 32'd1, 32'd2);
        chk("model sw imm", m.in2, 32'hFFFF_FFFC);
        m = model(32'h40109093, 32'h0, 32'd1, 32'd2);
        chk("model slli bad", {31'd0, m.ill}, 32'd1);
        tick();

        one_lit("add", 32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 4'h2, 1'b0);
        one_lit("srai", 32'h40435293, 32'h104, 32'h8000_0000, 32'd9,
                32'h8000_0000, 32'h404, 4'h9, 1'b0);
        one_lit("auipc", 32'h00002097, 32'h1000, 32'd1, 32'd2, 32'h1000, 32'h2000, 4'h2, 1'b0);
        one_lit("opc7f", 32'h0000007F, 32'h10C, 32'h55, 32'h66, 32'd0, 32'd0, 4'hF, 1'b1);
        one_lit("sub", 32'h40208233, 32'h110, 32'd10, 32'd3, 32'd10, 32'd3, 4'h6, 1'b0);
        one_lit("sll alt", 32'h40209233, 32'h114, 32'd10, 32'd3, 32'd0, 32'd0, 4'hF, 1'b1);
        one_lit("lui", 32'hABCDE0B7, 32'h118, 32'd10, 32'd3, 32'd0, 32'hABCDE000, 4'h2, 1'b0);

        // Stall: two accepted, third refused, outputs frozen, then FIFO drain
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h200, 32'd11, 32'd1);
        tick();
        drive(32'h002081B3, 32'h204, 32'd22, 32'd2);
        tick();
        drive(32'h002081B3, 32'h208, 32'd33, 32'd3);
        @(negedge clk);
        chk("full in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall head", alu_in1, 32'd11);
        tick();
        @(negedge clk);
        chk("stall frozen", alu_in1, 32'd11);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("drain 2nd", alu_in1, 32'd22);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain 3rd", alu_in1, 32'd33);
        tick();
        @(negedge clk);
        chk("drained", {31'd0, out_valid}, 32'd0);
        tick();

        // Flush with two buffered entries and a pending input
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h300, 32'd1, 32'd1);
        tick();
        drive(32'h002081B3, 32'h304, 32'd2, 32'd2);
        tick();
        flush = 1'b1;
        drive(32'h002081B3, 32'h308, 32'd3, 32'd3);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        // Flush with one entry while an input would have been accepted
        drive(32'h002081B3, 32'h30C, 32'd4, 32'd4);
        tick();
        flush = 1'b1;
        drive(32'h002081B3, 32'h310, 32'd5, 32'd5);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush drop", {31'd0, out_valid}, 32'd0);
        tick();

        // Reset mid-transfer
        drive(32'h002081B3, 32'h400, 32'd6, 32'd6);
        tick();
        drive(32'h002081B3, 32'h404, 32'd7, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid rst in1", alu_in1, 32'd0);
        chk("mid rst op", {28'd0, alu_op}, 32'hF);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("after rst out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Streaming with a stall pattern; model checks every cycle
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 3) != 2;
            drive(stream[idx % 18], 32'h800 + 32'(idx) * 4, 32'(idx) * 3 + 1,
                  32'hFFFF_0000 ^ 32'(idx));
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, operation code fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream offers instr/pc/rs1_data/rs2_data.
REQ-006 in_ready  output  1  block accepts an entry this cycle.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 pc  input  32  address of instr.
REQ-009 rs1_data  input  32  register-file read of instr[19:15].
REQ-010 rs2_data  input  32  register-file read of instr[24:20].
REQ-011 out_valid  output  1  decoded ALU operands available.
REQ-012 out_ready  input  1  ALU stage consumes the output this cycle.
REQ-013 alu_in1  output  32  ALU first operand.
REQ-014 alu_in2  output  32  ALU second operand.
REQ-015 alu_op  output  4  ALU operation code.
REQ-016 illegal  output  1  entry held unrecognised opcode/funct combination.

Function
REQ-017 Operation codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SRL 1000, SRA 1001, XOR 0101, SLT 1100, SLTU 1101, SLL 1010, NOP 1111.
REQ-018 OP (0110011): funct3 000 ADD/SUB by instr[30]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by instr[30]; 110 OR; 111 AND; in1=rs1, in2=rs2.
REQ-019 OP-IMM (0010011): same funct3 map, 000 always ADD; in2=sign-extended I-immediate; shifts use in2[4:0]=instr[24:20], SRA when instr[30]=1.
REQ-020 LOAD (0000011): ADD, in1=rs1, in2=I-imm; STORE (0100011): ADD, in1=rs1, in2=S-imm.
REQ-021 LUI: ADD, in1=0, in2={instr[31:12],12'b0}; AUIPC: ADD, in1=pc, same in2.
REQ-022 BRANCH: funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU; in1=rs1, in2=rs2; 010/011 illegal.
REQ-023 JAL, JALR: ADD, in1=pc, in2=32'd4 (link value).
REQ-024 Any other opcode, or OP with instr[31:25] not 0000000/0100000 (0100000 only for ADD/SUB, SRL/SRA), or illegal shift funct7 in OP-IMM: alu_op=NOP, in1=in2=0, illegal=1.
REQ-025 Latency: accepted entry appears on outputs the cycle after acceptance when buffer empty.
REQ-026 Buffering: two-entry skid buffer; in_ready = (entries < 2), computed from registered state only, no combinational path from out_ready.
REQ-027 Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready; simultaneous in and out with one entry keeps count at one, order preserved.
REQ-028 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-029 out_valid = (entries > 0); outputs always show the oldest entry.
REQ-030 flush: next cycle entries=0, out_valid=0; a concurrent input transfer is dropped.

Reset
REQ-031 On rst_n low: entries=0, out_valid=0, alu_in1=0, alu_in2=0, alu_op=1111, illegal=0; in_ready=1 from first cycle after release.
REQ-032 Reset mid-transfer discards all entries; no partial entry survives.

Structure
REQ-033 Shared package holds opcode constants, funct3 constants, and the ALU operation-code constants of REQ-017, used also by the ALU.
REQ-034 One sub-module, alu_issue_decode: purely combinational instr/pc/rs data -> {in1,in2,op,illegal}; alu_issue wraps it with the skid buffer.

Verification
REQ-035 add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=0010, in1=5, in2=7.
REQ-036 srai with imm=0x404, rs1=0x80000000 -> op=1001, in2[4:0]=4, illegal=0.
REQ-037 out_ready=0, three back-to-back valid inputs -> first two accepted, in_ready=0 on third, outputs frozen; release -> FIFO order.
REQ-038 auipc, pc=0x1000, instr[31:12]=0x00002 -> op=0010, in1=0x1000, in2=0x2000.
REQ-039 opcode 1111111 -> op=1111, in1=in2=0, illegal=1.
REQ-040 Two buffered entries then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; rst_n pulse mid-stream -> REQ-031 values.
